// File: rtl/lmem_pkg.sv
// rtl/lmem_pkg.sv - shared widths and FSM state type for the local-memory readers
package lmem_pkg;

   localparam int LMEM_ADDR_WIDTH = 6;
   localparam int LMEM_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } lmem_state_t;

endpackage

// File: rtl/lmem_skid_fifo.sv
// rtl/lmem_skid_fifo.sv - small synchronous FIFO that absorbs the BRAM read latency
module lmem_skid_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 2,
   localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_push_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_head,
   output logic                  o_full,
   output logic                  o_empty,
   output logic [CNT_W-1:0]      o_count
);

   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_W-1:0]      r_count;
   logic                  w_do_push;
   logic                  w_do_pop;

   // A push into a full FIFO is only taken when a pop frees a slot the same cycle.
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];

   // Storage array needs no reset; validity is tracked by the count.
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - fetches a run of BRAM bytes and streams them out with valid/ready
module bram_stream_reader
   import lmem_pkg::*;
#(
   parameter int ADDR_WIDTH = LMEM_ADDR_WIDTH,
   parameter int DATA_WIDTH = LMEM_DATA_WIDTH,
   parameter int BUF_DEPTH  = 2
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base_addr,
   input  logic [ADDR_WIDTH:0]   i_length,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic                  o_mem_wre,
   input  logic [DATA_WIDTH-1:0] i_mem_q,
   output logic [DATA_WIDTH-1:0] o_out_data,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic                  o_out_last,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   lmem_state_t           r_state;
   lmem_state_t           w_next_state;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [ADDR_WIDTH:0]   r_len;
   logic [ADDR_WIDTH:0]   r_issue_cnt;
   logic [ADDR_WIDTH:0]   r_pop_cnt;
   logic                  r_inflight;
   logic [ADDR_WIDTH-1:0] r_mem_addr;

   logic                  w_busy;
   logic                  w_done;
   logic                  w_pop;
   logic                  w_issue;
   logic                  w_last_idx;
   logic                  w_full;
   logic                  w_empty;
   logic [CNT_W-1:0]      w_count;
   logic [CNT_W:0]        w_occ;
   logic [CNT_W:0]        w_occ_limit;
   logic [DATA_WIDTH-1:0] w_head;

   lmem_skid_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUF_DEPTH)
   ) u_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (r_inflight),
      .i_push_data (i_mem_q),
      .i_pop       (w_pop),
      .o_head      (w_head),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_count     (w_count)
   );

   assign o_out_valid = ~w_empty;
   assign o_out_data  = w_head;
   assign w_pop       = o_out_valid & i_out_ready;
   assign w_last_idx  = (r_pop_cnt == (r_len - (ADDR_WIDTH+1)'(1)));
   assign o_out_last  = o_out_valid & w_last_idx;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wre   = 1'b0;
   assign o_busy      = w_busy;
   assign o_done      = w_done;

   // A read may issue only if its byte is guaranteed a buffer slot when it lands next cycle.
   assign w_occ       = {1'b0, w_count} + (CNT_W+1)'(r_inflight);
   assign w_occ_limit = (CNT_W+1)'(BUF_DEPTH) + (CNT_W+1)'(w_pop);
   assign w_issue     = (r_state == S_FETCH) && (r_issue_cnt != r_len) &&
                        (w_occ < w_occ_limit) && (~w_full | w_pop);

   // State register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and status decode; start is only honoured in IDLE.
   always_comb begin
      w_next_state = r_state;
      w_busy       = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_next_state = (i_length == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            w_busy = 1'b1;
            if (r_issue_cnt == r_len) begin
               w_next_state = S_DRAIN;
            end
         end
         S_DRAIN: begin
            w_busy = 1'b1;
            if (w_pop && w_last_idx && !r_inflight && (w_count == CNT_W'(1))) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_done       = 1'b1;
            w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Transfer latch, read issue (wrapping address) and handshake counters.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_base      <= '0;
         r_len       <= '0;
         r_issue_cnt <= '0;
         r_pop_cnt   <= '0;
         r_inflight  <= 1'b0;
         r_mem_addr  <= '0;
      end else begin
         r_inflight <= w_issue;
         if ((r_state == S_IDLE) && i_start) begin
            r_base      <= i_base_addr;
            r_len       <= i_length;
            r_issue_cnt <= '0;
            r_pop_cnt   <= '0;
         end else begin
            if (w_issue) begin
               r_mem_addr  <= r_base + r_issue_cnt[ADDR_WIDTH-1:0];
               r_issue_cnt <= r_issue_cnt + 1'b1;
            end
            if (w_pop) begin
               r_pop_cnt <= r_pop_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - scoreboard bench for the BRAM stream reader
module tb_bram_stream_reader;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [5:0] base_addr;
   logic [6:0] length;
   logic [5:0] mem_addr;
   logic       mem_wre;
   logic [7:0] mem_q;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       busy;
   logic       done;

   logic [7:0] ram [64];
   logic [8:0] exp_q [$];

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int hs_cnt = 0;
   int last_hs = -100;
   int rdy_mode = 0;
   int rdy_idx = 0;
   bit stall_prev = 0;
   logic [7:0] prev_data;
   logic       prev_last;

   bram_stream_reader dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start),
      .i_base_addr (base_addr),
      .i_length    (length),
      .o_mem_addr  (mem_addr),
      .o_mem_wre   (mem_wre),
      .i_mem_q     (mem_q),
      .o_out_data  (out_data),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_out_last  (out_last),
      .o_busy      (busy),
      .o_done      (done)
   );

   always #5 clk = ~clk;

   assign mem_q = ram[mem_addr];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Ready driver: mode 0 always ready, mode 1 repeats 1,0,0.
   always @(posedge clk) begin
      #1;
      if (rdy_mode == 0) begin
         out_ready = 1'b1;
      end else begin
         out_ready = ((rdy_idx % 3) == 0);
         rdy_idx++;
      end
   end

   // Monitor: compares every accepted byte with the scoreboard and checks stall stability.
   always @(negedge clk) begin
      if (!rst) begin
         check("mem_wre", int'(mem_wre), 0);
         if (stall_prev) begin
            check("stall_valid", int'(out_valid), 1);
            check("stall_data", int'(out_data), int'(prev_data));
            check("stall_last", int'(out_last), int'(prev_last));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_byte", int'(out_data), -1);
            end else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               check("data", int'(out_data), int'(e[7:0]));
               check("last", int'(out_last), int'(e[8]));
               hs_cnt++;
               if (out_last) last_hs = cyc;
            end
         end
         stall_prev = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end else begin
         stall_prev = 0;
      end
   end

   task automatic xfer(input int base, input int len, input bit spam);
      int s;
      int first_v;
      int d;
      int extra;
      for (int i = 0; i < len; i++) begin
         logic [8:0] e;
         e = {(i == len - 1) ? 1'b1 : 1'b0, 8'((base + i) % 64)};
         exp_q.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b1;
      base_addr = 6'(base);
      length = 7'(len);
      s = cyc + 1;
      @(posedge clk); #1;
      if (spam) begin
         base_addr = 6'd20;
         length = 7'd3;
      end else begin
         start = 1'b0;
      end
      first_v = -1;
      d = -1;
      for (int k = 0; k < 400 && d < 0; k++) begin
         @(negedge clk);
         if (cyc == s) check("busy_on", int'(busy), (len > 0) ? 1 : 0);
         if (out_valid && first_v < 0) first_v = cyc;
         if (done) d = cyc;
      end
      @(posedge clk); #1;
      start = 1'b0;
      check("done_seen", int'(d >= 0), 1);
      if (len == 0) begin
         check("done_lat_len0", d - s, 0);
         check("no_valid_len0", first_v, -1);
      end else begin
         check("done_after_last", d - last_hs, 1);
         check("first_valid_lat", first_v - s, 2);
      end
      extra = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done) extra++;
         check("busy_idle", int'(busy), 0);
      end
      check("extra_done", extra, 0);
      check("queue_drained", exp_q.size(), 0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) ram[i] = 8'(i);
      rst = 1'b1;
      start = 1'b0;
      base_addr = '0;
      length = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_addr", int'(mem_addr), 0);
      check("rst_last", int'(out_last), 0);
      @(posedge clk); #2;
      rst = 1'b0;

      // Reset in the middle of a fetch.
      begin
         int h0;
         int dn;
         for (int i = 0; i < 10; i++) begin
            logic [8:0] e;
            e = {(i == 9) ? 1'b1 : 1'b0, 8'(i)};
            exp_q.push_back(e);
         end
         @(posedge clk); #1;
         start = 1'b1; base_addr = 6'd0; length = 7'd10;
         @(posedge clk); #1;
         start = 1'b0;
         h0 = hs_cnt;
         for (int k = 0; k < 50 && hs_cnt < h0 + 3; k++) @(negedge clk);
         check("pre_reset_bytes", int'(hs_cnt >= h0 + 3), 1);
         @(posedge clk); #2;
         rst = 1'b1;
         #1;
         check("mid_rst_valid", int'(out_valid), 0);
         check("mid_rst_busy", int'(busy), 0);
         check("mid_rst_done", int'(done), 0);
         check("mid_rst_addr", int'(mem_addr), 0);
         check("mid_rst_last", int'(out_last), 0);
         exp_q.delete();
         @(posedge clk); #2;
         rst = 1'b0;
         dn = 0;
         for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (done) dn++;
         end
         check("no_done_after_abort", dn, 0);
      end
      xfer(0, 2, 0);

      xfer(4, 5, 0);
      xfer(62, 4, 0);

      rdy_idx = 0;
      rdy_mode = 1;
      xfer(0, 6, 0);
      rdy_mode = 0;

      xfer(0, 0, 0);
      xfer(0, 64, 0);

      xfer(10, 8, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
